// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN collective-control scheduler for a single elevator car
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 5,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [2:0]            floor_number,
    output logic                  dir,
    output logic                  move,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2
    } state_t;

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    localparam logic [2:0]    TOP_FLOOR   = 3'(NUM_FLOORS);

    state_t                  state_q, state_d;
    logic [2:0]              floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;

    logic [2:0]              cur;
    logic [2:0]              next_floor;
    logic [2:0]              next_idx;
    logic [NUM_FLOORS-1:0]   pend_req;
    logic [NUM_FLOORS-1:0]   clr;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [2:0] idx);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if ((3'(i) > idx) && v[i]) any_above = 1'b1;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [2:0] idx);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if ((3'(i) < idx) && v[i]) any_below = 1'b1;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [2:0] idx);
        onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (3'(i) == idx) onehot[i] = 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            floor_q   <= 3'd1;
            dir_q     <= 1'b1;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        tcnt_d     = tcnt_q;
        dcnt_d     = dcnt_q;
        clr        = '0;
        cur        = floor_q - 3'd1;
        next_floor = dir_q ? (floor_q + 3'd1) : (floor_q - 3'd1);
        next_idx   = next_floor - 3'd1;
        pend_req   = pending_q | req;

        case (state_q)
            S_IDLE: begin
                // Decisions use only already-latched requests, giving one cycle of latency.
                if (pending_q != '0) begin
                    if ((pending_q & onehot(cur)) != '0) begin
                        state_d = S_DOOR;
                        clr     = onehot(cur);
                        dcnt_d  = DOOR_LOAD;
                    end else begin
                        if (floor_q == 3'd1)
                            dir_d = 1'b1;
                        else if (floor_q == TOP_FLOOR)
                            dir_d = 1'b0;
                        else if (dir_q)
                            dir_d = any_above(pending_q, cur);
                        else
                            dir_d = !any_below(pending_q, cur);
                        state_d = S_MOVING;
                        tcnt_d  = TRAVEL_LOAD;
                    end
                end
            end
            S_MOVING: begin
                if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else begin
                    floor_d = next_floor;
                    if ((pend_req & onehot(next_idx)) != '0) begin
                        state_d = S_DOOR;
                        clr     = onehot(next_idx);
                        dcnt_d  = DOOR_LOAD;
                    end else if (dir_q ? any_above(pend_req, next_idx)
                                       : any_below(pend_req, next_idx)) begin
                        tcnt_d = TRAVEL_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                // A call for this floor while the door is open holds it rather than latching.
                clr = onehot(cur);
                if ((req & onehot(cur)) != '0)
                    dcnt_d = DOOR_LOAD;
                else if (dcnt_q == '0)
                    state_d = S_IDLE;
                else
                    dcnt_d = dcnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        pending_d = pend_req & ~clr;
    end

    always_comb begin
        floor_number = floor_q;
        dir          = dir_q;
        move         = (state_q == S_MOVING);
        door_open    = (state_q == S_DOOR);
        pending      = pending_q;
        busy         = (state_q != S_IDLE) || (pending_q != '0);
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - scoreboard bench for elevator_scheduler
module tb_elevator_scheduler;

    localparam int NF     = 5;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    localparam logic [1:0] K_STEP  = 2'd0;
    localparam logic [1:0] K_OPEN  = 2'd1;
    localparam logic [1:0] K_CLOSE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] floor;
        logic       dir;
        logic [7:0] dur;
    } ev_t;

    logic          clock;
    logic          reset;
    logic [NF-1:0] req;
    logic [2:0]    floor_number;
    logic          dir;
    logic          move;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          busy;

    int  checks = 0;
    int  passes = 0;
    ev_t sb_q[$];

    elevator_scheduler #(
        .NUM_FLOORS   (NF),
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .floor_number(floor_number),
        .dir         (dir),
        .move        (move),
        .door_open   (door_open),
        .pending     (pending),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input logic [1:0] k, input int f, input logic d, input int dur);
        ev_t e;
        e.kind  = k;
        e.floor = 3'(f);
        e.dir   = d;
        e.dur   = 8'(dur);
        sb_q.push_back(e);
    endtask

    task automatic expect_trip(input int from, input int to, input int door_dur);
        logic up;
        int   f;
        up = (to > from);
        f  = from;
        while (f != to) begin
            f = up ? f + 1 : f - 1;
            push(K_STEP, f, up, TRAVEL);
        end
        push(K_OPEN, to, 1'b0, 0);
        push(K_CLOSE, to, 1'b0, door_dur);
    endtask

    task automatic sb_compare(input string name, input ev_t got);
        ev_t exp;
        checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: unexpected event kind=%0d floor=%0d dir=%0d dur=%0d",
                     name, got.kind, got.floor, got.dir, got.dur);
        end else begin
            exp = sb_q.pop_front();
            if (got == exp) passes++;
            else $display("FAIL %s: got kind=%0d floor=%0d dir=%0d dur=%0d expected kind=%0d floor=%0d dir=%0d dur=%0d",
                          name, got.kind, got.floor, got.dir, got.dur,
                          exp.kind, exp.floor, exp.dir, exp.dur);
        end
    endtask

    task automatic pulse(input logic [NF-1:0] v);
        req = v;
        @(negedge clock);
        req = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < budget);
        if (busy) check({name, "_timeout"}, 1, 0);
    endtask

    // Monitor: turns DUT activity into step/open/close events and checks them in order.
    initial begin : monitor
        logic [2:0] prev_floor;
        logic       prev_door;
        int         mcount;
        int         dcount;
        ev_t        got;
        prev_floor = 3'd1;
        prev_door  = 1'b0;
        mcount     = 0;
        dcount     = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_floor = floor_number;
                prev_door  = 1'b0;
                mcount     = 0;
                dcount     = 0;
            end else begin
                if (floor_number != prev_floor) begin
                    got = '{K_STEP, floor_number, dir, 8'(mcount)};
                    sb_compare("step", got);
                    mcount = move ? 1 : 0;
                end else if (move) begin
                    mcount++;
                end
                if (door_open && !prev_door) begin
                    got = '{K_OPEN, floor_number, 1'b0, 8'd0};
                    sb_compare("door_open", got);
                    dcount = 1;
                end else if (door_open) begin
                    dcount++;
                end else if (prev_door) begin
                    got = '{K_CLOSE, floor_number, 1'b0, 8'(dcount)};
                    sb_compare("door_close", got);
                end
                if (move && door_open) check("move_and_door", 1, 0);
                prev_floor = floor_number;
                prev_door  = door_open;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $finish;
    end

    initial begin : stimulus
        int n;
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_floor", int'(floor_number), 1);
        check("rst_dir", int'(dir), 1);
        check("rst_move", int'(move), 0);
        check("rst_door", int'(door_open), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);

        // Single call to the top floor
        expect_trip(1, 5, DOOR);
        pulse(5'b10000);
        check("t1_pending", int'(pending), 5'b10000);
        check("t1_move_latency", int'(move), 0);
        check("t1_busy", int'(busy), 1);
        @(negedge clock);
        check("t1_move", int'(move), 1);
        check("t1_dir", int'(dir), 1);
        wait_idle("t1", 200);
        check("t1_floor", int'(floor_number), 5);
        check("t1_pending_end", int'(pending), 0);

        // Call back to the ground floor
        expect_trip(5, 1, DOOR);
        pulse(5'b00001);
        @(negedge clock);
        check("t2_dir", int'(dir), 0);
        check("t2_move", int'(move), 1);
        wait_idle("t2", 200);
        check("t2_floor", int'(floor_number), 1);

        // Intermediate calls picked up on the way
        expect_trip(1, 2, DOOR);
        expect_trip(2, 4, DOOR);
        expect_trip(4, 5, DOOR);
        pulse(5'b10000);
        @(negedge clock);
        pulse(5'b01010);
        wait_idle("t3", 300);
        check("t3_floor", int'(floor_number), 5);

        // Position the car at 3 heading up, then call both ends
        expect_trip(5, 1, DOOR);
        pulse(5'b00001);
        wait_idle("t4a", 200);
        expect_trip(1, 3, DOOR);
        pulse(5'b00100);
        wait_idle("t4b", 200);
        check("t4_at3_dir", int'(dir), 1);
        expect_trip(3, 5, DOOR);
        expect_trip(5, 1, DOOR);
        pulse(5'b10001);
        wait_idle("t4c", 300);
        check("t4_floor", int'(floor_number), 1);

        // Door held by repeated calls for the current floor
        expect_trip(1, 2, DOOR + 5);
        pulse(5'b00010);
        n = 0;
        while (!door_open && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t5_door_reached", int'(door_open), 1);
        req = 5'b00010;
        repeat (5) begin
            @(negedge clock);
            check("t5_hold_pending", int'(pending[1]), 0);
        end
        req = '0;
        check("t5_hold_door", int'(door_open), 1);
        wait_idle("t5", 100);
        check("t5_floor", int'(floor_number), 2);

        // Asynchronous reset during a step
        push(K_STEP, 3, 1'b1, TRAVEL);
        pulse(5'b10000);
        n = 0;
        while (floor_number != 3'd3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t6_reached3", int'(floor_number), 3);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_floor", int'(floor_number), 1);
        check("t6_rst_move", int'(move), 0);
        check("t6_rst_pending", int'(pending), 0);
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (10) @(negedge clock);
        check("t6_idle_floor", int'(floor_number), 1);
        check("t6_idle_move", int'(move), 0);
        check("t6_idle_busy", int'(busy), 0);

        repeat (3) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Collective-control scheduler for one elevator car. It latches floor requests into a pending register and picks travel direction with a SCAN policy: continue while requests lie ahead, reverse only when none remain. It sequences car motion and door dwell. It sits between the floor-button inputs and the car position/motion datapath, and drives floor_number, dir and move in the same encoding the car block uses.

Parameters:
NUM_FLOORS, 5, number of floors; legal 2..7; floors numbered 1..NUM_FLOORS
TRAVEL_CYCLES, 4, clock cycles spent in MOVING per one-floor step; >=1
DOOR_CYCLES, 3, clock cycles door_open is held per stop; >=1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_FLOORS  floor requests; bit i = floor i+1; level or pulse; sampled every rising edge
floor_number  output  3  current car floor, 1-based
dir  output  1  1 = up, 0 = down; meaningful while move=1
move  output  1  1 while car is travelling (state MOVING)
door_open  output  1  1 while in state DOOR
pending  output  NUM_FLOORS  latched, unserved requests
busy  output  1  1 when state != IDLE or pending != 0

Behaviour:
- Reset (reset=0, asynchronous): floor_number=1, dir=1, move=0, door_open=0, pending=0, state=IDLE, all counters 0. Takes effect immediately, including mid-travel or mid-door; no completion of a step in progress.
- Terms used below: cur = floor_number-1.
  - above = any pending bit at index > cur.
  - below = any pending bit at index < cur.
- Pending update each edge: pending <= (pending | req) & ~clr.
  - clr is a one-hot of the floor being served on that edge.
  - A req bit for the floor being served is dropped that cycle. It is not re-latched.
- FSM states: IDLE, MOVING, DOOR.
- IDLE:
  - pending=0: stay.
  - pending[cur]=1: go to DOOR, clear the bit, load door counter.
  - Otherwise choose dir. Keep the current dir if requests exist that way, else reverse. Go to MOVING with travel counter = TRAVEL_CYCLES-1.
  - Requests latched on edge k are acted on at edge k+1 (one-cycle decision latency).
- MOVING: move=1. The travel counter decrements each cycle. On the edge where the counter is 0:
  - floor_number steps +1 (dir=1) or -1 (dir=0).
  - Arrival check at the new floor uses pending|req:
    - Requested: go to DOOR with that bit cleared.
    - Else more requests lie ahead in dir: reload counter, stay in MOVING.
    - Else: go to IDLE.
  - Requests arriving mid-step for the floor being passed are not served on this pass.
- DOOR: door_open=1, move=0 for DOOR_CYCLES cycles, then IDLE.
  - req for cur during DOOR is not latched and reloads the door counter (door held).
  - dir is retained for the next IDLE decision.
- Boundaries:
  - Never step below 1 or above NUM_FLOORS. In IDLE, dir is forced to 1 at floor 1 and to 0 at NUM_FLOORS when a move is required.
  - Request bits at index >= NUM_FLOORS do not exist.
- Simultaneous requests above and below while IDLE: the previous dir wins. After reset that is up.
- move and door_open are never both 1.

Test Plan:
1. Reset, then req=5'b10000 pulsed one cycle.
   - Required: move=1 from the following edge, dir=1.
   - floor_number steps 1→2→3→4→5, one step every 4 cycles.
   - At floor 5: move=0 and door_open=1 for 3 cycles, pending=0, then busy=0.
2. Car idle at 5, req=5'b00001.
   - Required: dir=0; after 16 MOVING cycles floor_number=1, door_open=1.
3. Car at 1 moving up toward 5, req=5'b01010 asserted during the first step.
   - Required: stops at 2 (door 3 cycles), then at 4 (door 3 cycles).
   - Then continues to 5; the stop order is 2, 4, 5.
4. Car at 3 with last dir=1, req=5'b10001 simultaneously.
   - Required: goes up to 5 first, then reverses and serves 1.
5. Door open at floor 2, req=5'b00010 reasserted each cycle for 5 cycles.
   - Required: door_open stays 1 until 3 cycles after the last assertion.
   - pending[1] stays 0.
6. reset pulsed low mid-step while moving 3→4.
   - Required: immediately floor_number=1, move=0, pending=0.
   - After release, no motion until a new req.
